// File: rtl/nec_div_ctrl.sv
// rtl/nec_div_ctrl.sv - DIVU/DIV sequencer between execute microcode and the shared divider datapath
module nec_div_ctrl #(
  parameter int LAT_BYTE = 19,
  parameter int LAT_WORD = 35
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        flush,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_error,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_start,
  output logic        div_reset,
  output logic        div_wide,
  output logic [32:0] div_a,
  output logic [32:0] div_b,
  input  logic        div_done,
  input  logic        div_overflow,
  input  logic        div_dbz,
  input  logic [15:0] div_quot,
  input  logic [15:0] div_rem
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FINISH} state_t;

  localparam logic [6:0] LP_LAT_B = 7'(LAT_BYTE);
  localparam logic [6:0] LP_LAT_W = 7'(LAT_WORD);

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_seen, r_err_cap, r_err_flag, r_div_reset;
  logic [15:0] r_qcap, r_rcap, r_quot, r_rem;
  logic [32:0] r_a, r_b;

  logic [32:0] w_a_nxt, w_b_nxt;
  logic [6:0]  w_cnt_inc, w_lat;
  logic        w_have, w_err_now, w_err_fin;
  logic [15:0] w_q_fin, w_r_fin;

  always_comb begin
    w_a_nxt = '0;
    w_b_nxt = '0;
    case (op)
      2'b00: begin
        w_a_nxt = {17'b0, dividend[15:0]};
        w_b_nxt = {25'b0, divisor[7:0]};
      end
      2'b01: begin
        w_a_nxt = {{17{dividend[15]}}, dividend[15:0]};
        w_b_nxt = {{25{divisor[7]}}, divisor[7:0]};
      end
      2'b10: begin
        w_a_nxt = {1'b0, dividend};
        w_b_nxt = {17'b0, divisor};
      end
      default: begin
        w_a_nxt = {dividend[31], dividend};
        w_b_nxt = {{17{divisor[15]}}, divisor};
      end
    endcase
  end

  // Byte results must fit 8 bits; signed word results must carry the expected sign.
  always_comb begin
    w_err_now = div_dbz | div_overflow;
    if (!r_op[1]) begin
      if (r_op[0]) w_err_now = w_err_now | ~((&div_quot[15:7]) | ~(|div_quot[15:7]));
      else         w_err_now = w_err_now | (|div_quot[15:8]);
    end else if (r_op[0]) begin
      w_err_now = w_err_now | ((div_quot != 16'h0000) && (div_quot[15] != (r_a[32] ^ r_b[32])));
    end
  end

  assign w_have    = r_seen | div_done;
  assign w_cnt_inc = {1'b0, r_cnt} + 7'd1;
  assign w_lat     = r_op[1] ? LP_LAT_W : LP_LAT_B;
  assign w_err_fin = r_seen ? r_err_cap : w_err_now;
  assign w_q_fin   = r_seen ? r_qcap : div_quot;
  assign w_r_fin   = r_seen ? r_rcap : div_rem;

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_FINISH);
    div_start   = (r_state == S_START);
    if (ce) begin
      case (r_state)
        S_IDLE:   if (req && !flush) w_state_nxt = S_START;
        S_START:  w_state_nxt = flush ? S_IDLE : S_WAIT;
        S_WAIT: begin
          if (flush)                          w_state_nxt = S_IDLE;
          else if (w_have && w_cnt_inc >= w_lat) w_state_nxt = S_FINISH;
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_seen      <= 1'b0;
      r_err_cap   <= 1'b0;
      r_err_flag  <= 1'b0;
      r_div_reset <= 1'b0;
      r_qcap      <= '0;
      r_rcap      <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_a         <= '0;
      r_b         <= '0;
    end else if (ce) begin
      r_state     <= w_state_nxt;
      r_div_reset <= flush && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (req && !flush) begin
            r_op       <= op;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_cnt      <= 6'd1;
            r_seen     <= 1'b0;
            r_err_cap  <= 1'b0;
            r_err_flag <= 1'b0;
          end
        end
        S_START: r_cnt <= r_cnt + 6'd1;
        S_WAIT: begin
          if (r_cnt != 6'd63) r_cnt <= r_cnt + 6'd1;
          if (div_done && !r_seen) begin
            r_seen    <= 1'b1;
            r_err_cap <= w_err_now;
            r_qcap    <= div_quot;
            r_rcap    <= div_rem;
          end
          if (w_state_nxt == S_FINISH) begin
            r_err_flag <= w_err_fin;
            if (!w_err_fin) begin
              r_quot <= r_op[1] ? w_q_fin : {8'h00, w_q_fin[7:0]};
              r_rem  <= r_op[1] ? w_r_fin : {8'h00, w_r_fin[7:0]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign div_error = done & r_err_flag;
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign div_reset = r_div_reset;
  assign div_wide  = r_op[1];
  assign div_a     = r_a;
  assign div_b     = r_b;

endmodule

// File: tb/tb_nec_div_ctrl.sv
// tb/tb_nec_div_ctrl.sv - scoreboard bench for nec_div_ctrl with a behavioural divider
module tb_nec_div_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        flush = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_error, div_start, div_reset, div_wide;
  logic [15:0] quotient, remainder;
  logic [32:0] div_a, div_b;
  logic        div_done, div_overflow, div_dbz;
  logic [15:0] div_quot, div_rem;

  int vectors = 0;
  int miscompares = 0;
  bit gap_mode = 1'b0;
  int phase = 0;

  nec_div_ctrl #(.LAT_BYTE(19), .LAT_WORD(35)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .flush(flush), .req(req), .op(op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .div_error(div_error), .quotient(quotient), .remainder(remainder),
    .div_start(div_start), .div_reset(div_reset), .div_wide(div_wide),
    .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_overflow(div_overflow),
    .div_dbz(div_dbz), .div_quot(div_quot), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gap_mode) begin
        phase = (phase + 1) % 3;
        ce = (phase == 0);
      end else begin
        ce = 1'b1;
      end
    end
  end

  // Behavioural divider: truncating signed division of the 33-bit operands.
  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    logic        dbz;
  } mres_t;

  function automatic mres_t model_div(input logic [32:0] a, input logic [32:0] b);
    longint sa, sb, q, r;
    mres_t m;
    m = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      m.dbz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      m.q = q[15:0];
      m.r = r[15:0];
      m.ovf = (q > 65535) || (q < -65536);
    end
    return m;
  endfunction

  logic [5:0] m_cnt, m_tgt;
  mres_t      m_res;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= '0;
      m_tgt <= '0;
      m_res <= '0;
    end else if (ce) begin
      if (div_reset) begin
        m_cnt <= '0;
      end else if (div_start) begin
        m_res <= model_div(div_a, div_b);
        m_cnt <= 6'd2;
        m_tgt <= (div_b == '0) ? 6'd2 : (div_wide ? 6'd34 : 6'd18);
      end else if (m_cnt != 0 && m_cnt != 6'd63) begin
        m_cnt <= m_cnt + 6'd1;
      end
    end
  end

  assign div_done     = (m_cnt != 0) && (m_cnt == m_tgt);
  assign div_quot     = m_res.q;
  assign div_rem      = m_res.r;
  assign div_overflow = m_res.ovf;
  assign div_dbz      = m_res.dbz;

  typedef struct {
    string       name;
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
    int          cyc;
    logic [32:0] a;
    logic [32:0] b;
    logic        wide;
  } exp_t;

  exp_t sb_q[$];

  task automatic issue(input logic [1:0] o, input logic [31:0] dvd, input logic [15:0] dvs);
    @(negedge clk);
    op = o;
    dividend = dvd;
    divisor = dvs;
    req = 1'b1;
    do @(posedge clk); while (!ce);
    #1 req = 1'b0;
  endtask

  task automatic wait_done();
    exp_t e;
    int n = 1;
    int got = -1;
    int st_first = -1;
    int st_last = -1;
    for (int g = 0; g < 400 && got < 0; g++) begin
      @(negedge clk);
      if (div_start) begin
        if (st_first < 0) st_first = n;
        st_last = n;
      end
      if (done) got = n;
      else begin
        @(posedge clk);
        if (ce) n++;
      end
    end
    e = sb_q.pop_front();
    vectors++;
    if (got != e.cyc) begin
      miscompares++;
      $display("FAIL %s done_cycle: got %0d want %0d", e.name, got, e.cyc);
    end
    vectors++;
    if (st_first != 1 || st_last != 1) begin
      miscompares++;
      $display("FAIL %s div_start_cycle: got %0d..%0d want 1..1", e.name, st_first, st_last);
    end
    vectors++;
    if (quotient !== e.q || remainder !== e.r) begin
      miscompares++;
      $display("FAIL %s q/r: got %h/%h want %h/%h", e.name, quotient, remainder, e.q, e.r);
    end
    vectors++;
    if (div_error !== e.err || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s err/busy: got %b/%b want %b/1", e.name, div_error, busy, e.err);
    end
    vectors++;
    if (div_a !== e.a || div_b !== e.b || div_wide !== e.wide) begin
      miscompares++;
      $display("FAIL %s operands: got a=%h b=%h w=%b want a=%h b=%h w=%b",
               e.name, div_a, div_b, div_wide, e.a, e.b, e.wide);
    end
    do @(posedge clk); while (!ce);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_done busy/done: got %b/%b want 0/0", e.name, busy, done);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] dvd,
                        input logic [15:0] dvs, input logic [15:0] eq, input logic [15:0] er,
                        input logic eerr, input int ecyc, input logic [32:0] ea, input logic [32:0] eb);
    exp_t e;
    e.name = name; e.q = eq; e.r = er; e.err = eerr; e.cyc = ecyc;
    e.a = ea; e.b = eb; e.wide = o[1];
    sb_q.push_back(e);
    issue(o, dvd, dvs);
    wait_done();
  endtask

  task automatic check_all_zero(input string name);
    logic [103:0] v;
    v = {busy, done, div_error, quotient, remainder, div_start, div_reset, div_wide, div_a, div_b};
    vectors++;
    if (v !== '0) begin
      miscompares++;
      $display("FAIL %s outputs: got %h want 0", name, v);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu16();
    run_op("divu16", 2'b10, 32'h0001_0005, 16'h0002, 16'h8002, 16'h0001, 1'b0, 35,
           33'h0_0001_0005, 33'h0_0000_0002);
  endtask

  task automatic test_div8();
    run_op("div8", 2'b01, 32'h0000_FFF9, 16'h0002, 16'h00FD, 16'h00FF, 1'b0, 19,
           33'h1_FFFF_FFF9, 33'h0_0000_0002);
    run_op("div8_range", 2'b01, 32'h0000_FF80, 16'h00FF, 16'h00FD, 16'h00FF, 1'b1, 19,
           33'h1_FFFF_FF80, 33'h1_FFFF_FFFF);
  endtask

  task automatic test_dbz();
    run_op("divu8_dbz", 2'b00, 32'h0000_1234, 16'h0000, 16'h00FD, 16'h00FF, 1'b1, 19,
           33'h0_0000_1234, 33'h0_0000_0000);
  endtask

  task automatic test_div16();
    run_op("div16_min", 2'b11, 32'hFFFF_8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 35,
           33'h1_FFFF_8000, 33'h0_0000_0001);
    run_op("div16_sign", 2'b11, 32'h0000_8000, 16'h0001, 16'h8000, 16'h0000, 1'b1, 35,
           33'h0_0000_8000, 33'h0_0000_0001);
    run_op("divu16_ovf", 2'b10, 32'h0002_0000, 16'h0001, 16'h8000, 16'h0000, 1'b1, 35,
           33'h0_0002_0000, 33'h0_0000_0001);
  endtask

  task automatic test_flush();
    int n = 1;
    int rst_pulses = 0;
    int dones = 0;
    issue(2'b10, 32'h0001_0005, 16'h0002);
    while (n < 10) begin
      @(posedge clk);
      if (ce) n++;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || div_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL flush busy/done/div_reset: got %b/%b/%b want 0/0/1", busy, done, div_reset);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (div_reset) rst_pulses++;
      if (done) dones++;
    end
    vectors++;
    if (rst_pulses != 0 || dones != 0) begin
      miscompares++;
      $display("FAIL flush_after extra_reset/done: got %0d/%0d want 0/0", rst_pulses, dones);
    end
    req = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || div_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_req_idle busy/div_reset: got %b/%b want 0/0", busy, div_reset);
    end
    run_op("divu8_after_flush", 2'b00, 32'hABCD_0064, 16'h5507, 16'h000E, 16'h0002, 1'b0, 19,
           33'h0_0000_0064, 33'h0_0000_0007);
  endtask

  task automatic test_ce_gap();
    gap_mode = 1'b1;
    repeat (3) @(posedge clk);
    run_op("divu16_gap", 2'b10, 32'h0001_0005, 16'h0002, 16'h8002, 16'h0001, 1'b0, 35,
           33'h0_0001_0005, 33'h0_0000_0002);
    gap_mode = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int n = 1;
    issue(2'b10, 32'h0001_0005, 16'h0002);
    while (n < 20) begin
      @(posedge clk);
      if (ce) n++;
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_mid_wait");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op("divu8_after_reset", 2'b00, 32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 19,
           33'h0_0000_0064, 33'h0_0000_0007);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_divu16();
    test_div8();
    test_dbz();
    test_div16();
    test_flush();
    test_ce_gap();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
